// File: rtl/ux607_perips_pkg.sv
// Shared definitions for the peripheral-bus blocks: request-bundle field
// widths and a constant-evaluable clog2 helper.
package ux607_perips_pkg;

  localparam int REQ_IDX_W   = 10;
  localparam int REQ_DATA_W  = 32;
  localparam int REQ_EXTRA_W = 10;

  // Returns ceil(log2(v)); 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ux607_req_queue_ram.sv
// Request-queue storage: DEPTH x W flop array with one write port and one
// asynchronous read port. Contents are intentionally not reset.
module ux607_req_queue_ram #(
  parameter int DEPTH = 2,
  parameter int W     = 57,
  parameter int AW    = 1
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ux607_req_queue.sv
// Parametrised request FIFO for the peripheral-bus request bundle, with
// optional pipe (enq while full and draining) and flow (empty bypass) modes.
module ux607_req_queue
  import ux607_perips_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int IDX_W    = REQ_IDX_W,
  parameter int DATA_W   = REQ_DATA_W,
  parameter int EXTRA_W  = REQ_EXTRA_W,
  parameter int PIPE     = 1,
  parameter int FLOW     = 0,
  parameter int AFULL_TH = DEPTH - 1,
  localparam int CNT_W   = clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                io_enq_ready,
  input  logic                io_enq_valid,
  input  logic                io_enq_bits_read,
  input  logic [IDX_W-1:0]    io_enq_bits_index,
  input  logic [DATA_W-1:0]   io_enq_bits_data,
  input  logic [DATA_W/8-1:0] io_enq_bits_mask,
  input  logic [EXTRA_W-1:0]  io_enq_bits_extra,
  input  logic                io_deq_ready,
  output logic                io_deq_valid,
  output logic                io_deq_bits_read,
  output logic [IDX_W-1:0]    io_deq_bits_index,
  output logic [DATA_W-1:0]   io_deq_bits_data,
  output logic [DATA_W/8-1:0] io_deq_bits_mask,
  output logic [EXTRA_W-1:0]  io_deq_bits_extra,
  output logic [CNT_W-1:0]    io_count,
  output logic                io_almost_full
);

  localparam int  PTR_W   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int  W       = 1 + IDX_W + DATA_W + DATA_W / 8 + EXTRA_W;
  localparam bit  PIPE_EN = (PIPE != 0);
  localparam bit  FLOW_EN = (FLOW != 0);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] enq_ptr, deq_ptr;
  logic             maybe_full;
  logic             ptr_match, empty, full;
  logic             do_enq, do_deq, bypass, wr_en, rd_adv;
  logic [W-1:0]     enq_bundle, ram_rdata, deq_bundle;
  logic [CNT_W-1:0] ep_ext, dp_ext;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  // Handshake: a transfer happens on a side in any cycle where both valid and
  // ready are high; valid never depends on the same side's ready, and deq bits
  // are only meaningful while io_deq_valid is high.
  assign io_enq_ready = ~full | (PIPE_EN & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW_EN & io_enq_valid);
  assign do_enq       = io_enq_ready & io_enq_valid;
  assign do_deq       = io_deq_ready & io_deq_valid;

  // A flow bypass hands the enq bundle straight to deq and leaves state alone.
  assign bypass = FLOW_EN & empty & io_deq_ready;
  assign wr_en  = do_enq & ~bypass;
  assign rd_adv = do_deq & ~bypass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (wr_en)  enq_ptr <= (enq_ptr == LAST) ? '0 : enq_ptr + 1'b1;
      if (rd_adv) deq_ptr <= (deq_ptr == LAST) ? '0 : deq_ptr + 1'b1;
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end

  assign enq_bundle = {io_enq_bits_read, io_enq_bits_index, io_enq_bits_data,
                       io_enq_bits_mask, io_enq_bits_extra};

  ux607_req_queue_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (PTR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (enq_ptr),
    .wr_data (enq_bundle),
    .rd_addr (deq_ptr),
    .rd_data (ram_rdata)
  );

  assign deq_bundle = (FLOW_EN & empty) ? enq_bundle : ram_rdata;
  assign {io_deq_bits_read, io_deq_bits_index, io_deq_bits_data,
          io_deq_bits_mask, io_deq_bits_extra} = deq_bundle;

  // Occupancy wraps modulo DEPTH, so a behind enq_ptr needs +DEPTH.
  assign ep_ext = CNT_W'(enq_ptr);
  assign dp_ext = CNT_W'(deq_ptr);
  assign io_count = full                ? CNT_W'(DEPTH) :
                    (enq_ptr >= deq_ptr) ? (ep_ext - dp_ext) :
                                           (ep_ext + CNT_W'(DEPTH) - dp_ext);

  assign io_almost_full = (int'(io_count) >= AFULL_TH);

endmodule

// File: doc/ux607_req_queue.md
Name: ux607_req_queue

Overview:
Parametrised request FIFO carrying the peripheral-bus request bundle (read, index, data, mask, extra) between a bus master and a peripheral port.
- Generalises the single-entry pipe queue to DEPTH entries with configurable field widths.
- Adds optional pipe and flow modes, a full-width occupancy count and an almost-full flag.
- Instantiated on peripheral request/response paths wherever buffering between bus stages is needed.

Parameters:
DEPTH, 2, number of entries (>=1; need not be a power of two)
IDX_W, 10, width of index field
DATA_W, 32, width of data field (multiple of 8)
EXTRA_W, 10, width of extra field
PIPE, 1, 1 = enq_ready also asserted when full and io_deq_ready=1
FLOW, 0, 1 = when empty, enq bundle bypasses storage to deq in the same cycle
AFULL_TH, DEPTH-1, count at or above which io_almost_full asserts
CNT_W, clog2(DEPTH+1), derived, width of io_count

Ports:
clock  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
io_enq_ready  out  1  queue accepts enq this cycle
io_enq_valid  in  1  enq bundle valid
io_enq_bits_read  in  1  read (1) / write (0)
io_enq_bits_index  in  IDX_W  word index
io_enq_bits_data  in  DATA_W  write data
io_enq_bits_mask  in  DATA_W/8  byte mask
io_enq_bits_extra  in  EXTRA_W  sideband tag
io_deq_ready  in  1  consumer accepts deq
io_deq_valid  out  1  deq bundle valid
io_deq_bits_read  out  1  head read flag
io_deq_bits_index  out  IDX_W  head index
io_deq_bits_data  out  DATA_W  head data
io_deq_bits_mask  out  DATA_W/8  head mask
io_deq_bits_extra  out  EXTRA_W  head extra
io_count  out  CNT_W  occupancy, 0..DEPTH
io_almost_full  out  1  io_count >= AFULL_TH

Behaviour:
- State: enq_ptr and deq_ptr (clog2(DEPTH) bits each, minimum 1) and maybe_full.
  - Reset (async) clears all three.
  - After reset: io_count=0, io_deq_valid=0, io_enq_ready=1, io_almost_full=(AFULL_TH==0).
  - Storage array is not reset; deq bits are don't-care while io_deq_valid=0.
- empty = (enq_ptr==deq_ptr) & !maybe_full.
- full = (enq_ptr==deq_ptr) & maybe_full.
- Base handshake:
  - io_deq_valid = !empty.
  - io_enq_ready = !full, OR'd with io_deq_ready when PIPE=1.
  - do_enq = enq_ready & enq_valid.
  - do_deq = deq_ready & deq_valid.
- Flow mode (FLOW=1) while empty:
  - io_deq_valid = io_enq_valid, and deq bits = enq bits combinationally.
  - If io_deq_ready=1: no write and no pointer change (zero-latency pass-through).
  - If io_deq_ready=0: the entry is written normally.
- Write: on do_enq (excluding a flow bypass), store the bundle at enq_ptr; enq_ptr advances.
- Read: deq bits come from storage at deq_ptr (asynchronous read); on do_deq (excluding a flow bypass), deq_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 wraps to 0. Non-power-of-two DEPTH must be handled explicitly.
- maybe_full update: when do_enq != do_deq, maybe_full <= do_enq; otherwise it holds.
- Simultaneous enq and deq:
  - Both pointers advance; occupancy is unchanged.
  - When full with PIPE=1, the enq write and the head read target the same slot. The read returns the old entry this cycle; the write lands at the clock edge.
- io_count:
  - full -> DEPTH.
  - otherwise -> (enq_ptr - deq_ptr) mod DEPTH, computed in CNT_W bits with an explicit +DEPTH correction when enq_ptr < deq_ptr.
- Latency: 1 cycle from enq to deq when not bypassing; 0 cycles for a flow bypass.
- DEPTH=1, PIPE=1, FLOW=0 must be cycle-equivalent to the existing single-entry queue, with io_count 1 bit wide.
- Reset asserted mid-operation: the queue empties immediately and asynchronously. No deq bundle issued before reset is replayed.

Decomposition:
- Shared package ux607_perips_pkg holds:
  - the request-bundle field widths (IDX_W, DATA_W, EXTRA_W defaults);
  - the clog2 helper function.
- Sub-module ux607_req_queue_ram holds the storage:
  - DEPTH x (1+IDX_W+DATA_W+DATA_W/8+EXTRA_W) flop array;
  - one write port and one asynchronous read port.
- Pointer, flag and count logic stays in the top module.

Test Plan:
- Reset then idle: io_count=0, io_deq_valid=0, io_enq_ready=1, io_almost_full=0 (DEPTH=4, AFULL_TH=3).
- DEPTH=4, deq_ready=0: enqueue 4 bundles with index 0x001..0x004.
  - io_count steps 1,2,3,4; io_almost_full rises at count 3; io_enq_ready=0 after the 4th.
  - Then deq_ready=1: index 0x001..0x004 dequeued in order, count back to 0.
- DEPTH=3 (non-power-of-two): 10 enqueues interleaved with 10 dequeues.
  - Pointers wrap 2->0 and io_count never exceeds 3.
  - Data 0xA0000000+n returned in order.
- PIPE=1, full, enq_valid=1 and deq_ready=1 in the same cycle:
  - io_enq_ready=1, the head is dequeued, the new entry is accepted and io_count stays 4.
  - With PIPE=0 the same stimulus gives io_enq_ready=0.
- FLOW=1, empty, enq_valid=1 with data 0xDEADBEEF and deq_ready=1:
  - io_deq_valid=1 with data 0xDEADBEEF in the same cycle; io_count stays 0.
  - Same stimulus with deq_ready=0: the entry is stored and io_count=1 next cycle.
- Assert reset asynchronously mid-cycle with count=2:
  - io_deq_valid falls without waiting for a clock edge and io_count=0.
  - The next enqueue of mask 0xF is returned first after reset.
